// File: rtl/oai_sweep_checker.sv
// Exhaustive sweep engine for OAI/OA cell models.
// Drives every input pattern, compares against a golden model, logs errors.
module oai_sweep_checker #(
  parameter int GROUPS  = 2,
  parameter int GROUP_W = 2,
  parameter int SETTLE  = 2,
  parameter int INV_OUT = 1,
  localparam int N = GROUPS * GROUP_W
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         start,
  output logic [N-1:0] stim,
  input  logic         dut_zn,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_fail,
  output logic         fail_valid
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FIN
  } state_t;

  localparam state_t FIRST = (SETTLE == 0) ? SAMPLE : DRIVE;
  localparam logic [7:0] SET_LAST = 8'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t     state;
  logic [7:0] cnt;
  logic       gold;
  logic       mis;

  function automatic logic golden(input logic [N-1:0] s);
    logic a;
    a = 1'b1;
    for (int g = 0; g < GROUPS; g++)
      a = a & (|s[N-1-g*GROUP_W -: GROUP_W]);
    return (INV_OUT != 0) ? ~a : a;
  endfunction

  assign gold = golden(stim);
  // case-inequality so an undriven cell output is flagged
  assign mis  = (dut_zn !== gold);

  always_ff @(posedge CK) begin
    if (!RN) begin
      state      <= IDLE;
      cnt        <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= FIRST;
            cnt        <= '0;
            stim       <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt == SET_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SAMPLE: begin
          if (mis) begin
            err_cnt <= err_cnt + (N+1)'(1);
            if (!fail_valid) begin
              first_fail <= stim;
              fail_valid <= 1'b1;
            end
          end
          if (&stim) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mis;
          end else begin
            stim  <= stim + N'(1);
            state <= FIRST;
          end
        end
        FIN: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
